// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: merges two AXI write requesters onto one master port, with AW starvation guard and in-order W routing.
module axi_wr_arbiter #(
   parameter int unsigned MaxWTxns    = 4,
   parameter int unsigned StarveLimit = 8,
   parameter type         aw_chan_t   = logic,
   parameter type         w_chan_t    = logic,
   parameter int unsigned WLastBit    = 0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [1:0]     slv_aw_valid_i,
   input  aw_chan_t [1:0] slv_aw_i,
   output logic [1:0]     slv_aw_ready_o,
   input  logic [1:0]     slv_w_valid_i,
   input  w_chan_t [1:0]  slv_w_i,
   output logic [1:0]     slv_w_ready_o,
   output logic           mst_aw_valid_o,
   output aw_chan_t       mst_aw_o,
   input  logic           mst_aw_ready_i,
   output logic           mst_aw_sel_o,
   output logic           mst_w_valid_o,
   output w_chan_t        mst_w_o,
   input  logic           mst_w_ready_i,
   output logic           busy_o
);
   localparam int unsigned PtrW = MaxWTxns > 1 ? $clog2(MaxWTxns) : 1;
   localparam int unsigned CntW = $clog2(MaxWTxns + 1);
   localparam int unsigned WW   = $bits(w_chan_t);
   localparam logic [CntW-1:0] Full    = CntW'(MaxWTxns);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxWTxns - 1);
   localparam logic [7:0]      Limit   = 8'(StarveLimit);

   typedef enum logic {IDLE, HOLD} state_e;

   state_e                r_state, w_state_nxt;
   aw_chan_t              r_aw;
   logic                  r_sel;
   logic [MaxWTxns-1:0]   r_fifo;
   logic [PtrW-1:0]       r_wr, r_rd;
   logic [CntW-1:0]       r_cnt;
   logic [7:0]            r_starve;
   logic                  w_grant, w_sel, w_pop, w_head, w_has_w, w_last;
   logic [WW-1:0]         w_w_bits;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      mst_aw_valid_o = 1'b0;
      w_grant        = 1'b0;
      case (r_state)
         IDLE: begin
            w_grant     = |slv_aw_valid_i && r_cnt != Full && !rst_i;
            w_state_nxt = w_grant ? HOLD : IDLE;
         end
         HOLD: begin
            mst_aw_valid_o = !rst_i;
            w_state_nxt    = mst_aw_ready_i ? IDLE : HOLD;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Port 1 wins unless port 0 has waited through StarveLimit port-1 grants.
   assign w_sel          = slv_aw_valid_i[1] && !(r_starve == Limit && slv_aw_valid_i[0]);
   assign slv_aw_ready_o = {w_grant & w_sel, w_grant & !w_sel};
   assign mst_aw_o       = r_aw;
   assign mst_aw_sel_o   = r_sel;

   assign w_head        = r_fifo[r_rd];
   assign w_has_w       = r_cnt != '0 && !rst_i;
   assign mst_w_o       = slv_w_i[w_head];
   assign mst_w_valid_o = w_has_w & slv_w_valid_i[w_head];
   assign slv_w_ready_o = w_has_w ? {w_head & mst_w_ready_i, !w_head & mst_w_ready_i} : 2'b00;
   assign w_w_bits      = mst_w_o;
   assign w_last        = |(w_w_bits & (WW'(1) << WLastBit));
   assign w_pop         = mst_w_valid_o & mst_w_ready_i & w_last;
   assign busy_o        = !rst_i && (r_cnt != '0 || r_state == HOLD);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_aw     <= '0;
         r_sel    <= 1'b0;
         r_fifo   <= '0;
         r_wr     <= '0;
         r_rd     <= '0;
         r_cnt    <= '0;
         r_starve <= '0;
      end else begin
         if (w_grant) begin
            r_aw         <= slv_aw_i[w_sel];
            r_sel        <= w_sel;
            r_fifo[r_wr] <= w_sel;
            r_wr         <= r_wr == PtrLast ? '0 : r_wr + 1'b1;
            r_starve     <= (!slv_aw_valid_i[0] || !w_sel) ? '0 :
                            r_starve == Limit ? r_starve : r_starve + 1'b1;
         end
         if (w_pop) r_rd <= r_rd == PtrLast ? '0 : r_rd + 1'b1;
         r_cnt <= r_cnt + CntW'(w_grant) - CntW'(w_pop);
      end
   end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed-vector bench for axi_wr_arbiter (W payload = {data[7:0], last}).
module tb_axi_wr_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      aw_v, aw_r, w_v, w_r;
   logic [1:0][7:0] aw;
   logic [1:0][8:0] w;
   logic            m_aw_v, m_aw_r, m_sel, m_w_v, m_w_r, busy;
   logic [7:0]      m_aw;
   logic [8:0]      m_w;
   int              n_vec = 0, n_err = 0;

   axi_wr_arbiter #(
      .MaxWTxns(4), .StarveLimit(8),
      .aw_chan_t(logic [7:0]), .w_chan_t(logic [8:0])
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .slv_aw_valid_i(aw_v), .slv_aw_i(aw), .slv_aw_ready_o(aw_r),
      .slv_w_valid_i(w_v), .slv_w_i(w), .slv_w_ready_o(w_r),
      .mst_aw_valid_o(m_aw_v), .mst_aw_o(m_aw), .mst_aw_ready_i(m_aw_r), .mst_aw_sel_o(m_sel),
      .mst_w_valid_o(m_w_v), .mst_w_o(m_w), .mst_w_ready_i(m_w_r),
      .busy_o(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sel, ep, d0, d1, e0, e1;
      rst = 1'b1; aw_v = 2'b11; w_v = 2'b11; m_aw_r = 1'b1; m_w_r = 1'b1;
      aw[0] = 8'hA0; aw[1] = 8'hB1; w[0] = {8'h10, 1'b1}; w[1] = {8'h20, 1'b1};
      tick; tick; #1;
      chk("rst_aw_ready", aw_r, 2'b00);
      chk("rst_w_ready", w_r, 2'b00);
      chk("rst_aw_valid", m_aw_v, 0);
      chk("rst_w_valid", m_w_v, 0);
      chk("rst_busy", busy, 0);
      tick; rst = 1'b0;
      for (int g = 0; g < 18; g++) begin
         sel = (g % 9 == 8) ? 0 : 1;
         #1;
         chk("starve_grant", aw_r, sel ? 2'b10 : 2'b01);
         tick; #1;
         chk("starve_aw_valid", m_aw_v, 1);
         chk("starve_sel", m_sel, sel);
         chk("starve_aw_pay", m_aw, sel ? 8'hB1 : 8'hA0);
         chk("starve_w_valid", m_w_v, 1);
         chk("starve_w_pay", m_w, sel ? {8'h20, 1'b1} : {8'h10, 1'b1});
         tick;
      end
      aw_v = 2'b00; w_v = 2'b00;
      tick;
      aw_v = 2'b01; m_aw_r = 1'b0; #1;
      chk("early_grant", aw_r, 2'b01);
      tick; aw_v = 2'b00;
      for (int b = 0; b < 4; b++) begin
         w[0] = {8'(8'h50 + b), 1'(b == 3)}; w[1] = {8'h60, 1'b1}; w_v = 2'b11; #1;
         chk("early_w_valid", m_w_v, 1);
         chk("early_w_pay", m_w, {8'(8'h50 + b), 1'(b == 3)});
         chk("early_w_ready", w_r, 2'b01);
         chk("early_aw_valid", m_aw_v, 1);
         chk("early_aw_pay", m_aw, 8'hA0);
         chk("early_busy", busy, 1);
         tick;
      end
      w_v = 2'b00; #1;
      chk("early_hold_valid", m_aw_v, 1);
      chk("early_hold_busy", busy, 1);
      chk("early_fifo_empty", m_w_v, 0);
      chk("early_w_ready_empty", w_r, 2'b00);
      tick; m_aw_r = 1'b1; #1;
      chk("early_aw_hs", m_aw_v, 1);
      tick; #1;
      chk("early_done_valid", m_aw_v, 0);
      chk("early_done_busy", busy, 0);
      tick;
      m_w_r = 1'b0; aw_v = 2'b10;
      for (int k = 0; k < 4; k++) begin
         #1; chk("fill_grant", aw_r, 2'b10);
         tick; tick;
      end
      #1;
      chk("full_no_grant", aw_r, 2'b00);
      chk("full_busy", busy, 1);
      tick; #1;
      chk("full_no_grant2", aw_r, 2'b00);
      tick;
      w[1] = {8'h70, 1'b1}; w_v = 2'b10; m_w_r = 1'b1; #1;
      chk("full_pop_no_grant", aw_r, 2'b00);
      chk("full_pop_w_ready", w_r, 2'b10);
      tick;
      w_v = 2'b00; m_w_r = 1'b0; #1;
      chk("after_pop_grant", aw_r, 2'b10);
      tick;
      aw_v = 2'b00; w_v = 2'b10; m_w_r = 1'b1;
      tick; tick; tick; tick; #1;
      chk("drain_busy", busy, 0);
      chk("drain_w_valid", m_w_v, 0);
      w_v = 2'b00;
      tick;
      d0 = 0; d1 = 0; e0 = 0; e1 = 0;
      for (int r = 0; r < 4; r++) begin
         m_w_r = 1'b0; w_v = 2'b00;
         aw_v = 2'b10; tick;
         aw_v = 2'b00; #1; chk("ilv_sel_a", m_sel, 1); tick;
         aw_v = 2'b01; tick;
         aw_v = 2'b00; #1; chk("ilv_sel_b", m_sel, 0); tick;
         aw_v = 2'b10; tick;
         aw_v = 2'b00; #1; chk("ilv_sel_c", m_sel, 1); tick;
         m_w_r = 1'b1; w_v = 2'b11;
         for (int i = 0; i < 6; i++) begin
            w[0] = {8'(8'h30 + d0), 1'(d0 % 2)};
            w[1] = {8'(8'h40 + d1), 1'(d1 % 2)};
            #1;
            ep = (i == 2 || i == 3) ? 0 : 1;
            chk("ilv_w_valid", m_w_v, 1);
            chk("ilv_w_pay", m_w, ep ? {8'(8'h40 + e1), 1'(e1 % 2)} : {8'(8'h30 + e0), 1'(e0 % 2)});
            if (ep == 1) e1++; else e0++;
            if (w_r[0]) d0++;
            if (w_r[1]) d1++;
            tick;
         end
         w_v = 2'b00; #1;
         chk("ilv_busy", busy, 0);
         tick;
      end
      m_w_r = 1'b0; w_v = 2'b00; aw_v = 2'b10; tick;
      aw_v = 2'b00; tick;
      aw_v = 2'b10; tick;
      aw_v = 2'b00; m_aw_r = 1'b0; rst = 1'b1; #1;
      chk("midrst_aw_valid", m_aw_v, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_aw_ready", aw_r, 2'b00);
      tick;
      rst = 1'b0; w_v = 2'b11; m_w_r = 1'b1; #1;
      chk("postrst_aw_valid", m_aw_v, 0);
      chk("postrst_busy", busy, 0);
      chk("postrst_w_ready", w_r, 2'b00);
      chk("postrst_w_valid", m_w_v, 0);
      tick;
      w_v = 2'b00; aw_v = 2'b10; m_aw_r = 1'b1; #1;
      chk("postrst_grant", aw_r, 2'b10);
      tick;
      aw_v = 2'b00; #1;
      chk("postrst_hold", m_aw_v, 1);
      chk("postrst_sel", m_sel, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
